// File: rtl/risc_pkg.sv
// Shared miniRISC constants and the register-dump FSM state type.
// The CSUM state exists only when REG_DUMP_CHECKSUM_EN is defined.
package risc_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int DATA_W   = 32;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_CSUM  = 2'd3
    } dump_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } dump_state_e;
`endif

    // Address increment wraps modulo NUM_REGS through the natural width.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a + ADDR_ONE;
    endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Register-file dump engine: walks a wrap-around address range and streams
// each word over valid/ready. Optional checksum beat: REG_DUMP_CHECKSUM_EN.
module reg_dump_reader
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] firstAddr,
    input  logic [ADDR_W-1:0] lastAddr,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] rdData,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outData,
    output logic [ADDR_W-1:0] outAddr,
    output logic              outLast,
    output logic              busy,
    output logic              done
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    // Next-state and output-register logic for the dump FSM.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = firstAddr;
                    end_d   = lastAddr;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d  = {DATA_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                data_d  = rdData;
                addr_d  = cur_q;
                valid_d = 1'b1;
                state_d = ST_SEND;
`ifdef REG_DUMP_CHECKSUM_EN
                last_d  = 1'b0;
                csum_d  = csum_q ^ rdData;
`else
                last_d  = (cur_q == end_q);
`endif
            end
            ST_SEND: begin
                // outLast marks the true final beat in both builds.
                if (valid_q && outReady) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
`ifdef REG_DUMP_CHECKSUM_EN
                    end else if (cur_q == end_q) begin
                        state_d = ST_CSUM;
`endif
                    end else begin
                        cur_d   = next_addr(cur_q);
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                data_d  = csum_q;
                addr_d  = {ADDR_W{1'b0}};
                last_d  = 1'b1;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cur_q   <= {ADDR_W{1'b0}};
            end_q   <= {ADDR_W{1'b0}};
            valid_q <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign rdAddr   = (state_q == ST_IDLE) ? {ADDR_W{1'b0}} : cur_q;
    assign outValid = valid_q;
    assign outData  = data_q;
    assign outAddr  = addr_q;
    assign outLast  = last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the miniRISC core. On a start pulse it walks a contiguous, wrap-around range of register-file addresses through a dedicated combinational read port. It streams each captured word, with its address, over a valid/ready interface to the test/host side. It is the reader counterpart of the register file's write path and is used by benches and debug logic to extract the full architectural state after a program run.

## Interface
- NUM_REGS, 32, number of architectural registers; must be a power of two.
- ADDR_W, 5, register address width, log2(NUM_REGS).
- DATA_W, 32, register data width.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a dump; sampled only in IDLE.
- firstAddr  in  ADDR_W  first register of the range; sampled with start.
- lastAddr  in  ADDR_W  last register of the range, inclusive; sampled with start.
- rdAddr  out  ADDR_W  address driven to the register file's read port.
- rdData  in  DATA_W  combinational read data returned for rdAddr.
- outValid  out  1  beat available.
- outReady  in  1  consumer accepts the beat.
- outData  out  DATA_W  register value, or checksum on the checksum beat.
- outAddr  out  ADDR_W  register address of the beat.
- outLast  out  1  final beat of the dump.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- FSM states: IDLE, FETCH, SEND, plus CSUM when the checksum is compiled in.
- IDLE:
  - On start=1: latch cur<=firstAddr and end<=lastAddr, clear checksum, go to FETCH.
  - start is ignored in every other state.
- rdAddr = cur at all times, and 0 in IDLE.
- FETCH:
  - outData<=rdData, outAddr<=cur, outLast<=(cur==end) when CSUM is absent.
  - checksum ^= rdData.
  - outValid<=1, then go to SEND.
- SEND, on outValid && outReady:
  - If cur==end: go to CSUM if enabled; otherwise go to IDLE and pulse done.
  - Otherwise: cur<=cur+1, wrapping modulo NUM_REGS, and go to FETCH. outValid drops for the FETCH cycle.
- Range length is ((lastAddr-firstAddr) mod NUM_REGS)+1:
  - firstAddr==lastAddr gives one beat.
  - firstAddr>lastAddr wraps through NUM_REGS-1 to 0.
- Coherency is per word only. Each value is captured in its own FETCH cycle, so writes landing mid-dump are visible for addresses not yet fetched.
- Reset, asynchronous and valid at any time including mid-dump:
  - state=IDLE, cur=0.
  - outValid=0, outData=0, outAddr=0, outLast=0.
  - busy=0, done=0, checksum=0.
  - The in-progress dump is abandoned; no resume.

## Timing
- Start accepted in cycle 0 → FETCH in cycle 1 → outValid=1 in cycle 2.
- Throughput: one beat per 2 cycles with outReady held high.
- While outValid=1 and outReady=0: outData, outAddr and outLast are held stable and outValid stays high.
- outValid never drops without a handshake.
- busy: high from cycle 1 through the cycle in which the final beat handshakes.
- done: high for exactly the cycle after that handshake. A new start is accepted in that same cycle.
- Total dump with outReady=1: 2·N cycles from start to final handshake, plus 2 cycles when CSUM is enabled.

## Configuration
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - After the last register beat, the FSM enters CSUM and emits one extra beat.
  - That beat carries outData = XOR of all emitted register words, outAddr=0, outLast=1.
  - The register beat for lastAddr then has outLast=0.
  - done pulses after the checksum beat handshakes.
- Undefined:
  - No CSUM state and no checksum register.
  - outLast is asserted on the lastAddr beat.

## Structure
- Shared package risc_pkg: NUM_REGS, ADDR_W, DATA_W constants and the dump FSM state enum typedef.
- No sub-module. The FSM, address counter, output register and checksum are all inline.

## Test plan
- Full dump: registers preloaded with reg[k]=0x100+k, first=0, last=31, outReady=1.
  - Expect 32 beats with addresses 0..31 and data 0x100..0x11F, one beat every 2 cycles.
  - outLast on address 31 only; done pulses once; busy high for 64 cycles.
- Backpressure: outReady=0 for 5 cycles at beat 3, with start pulsed during that stall.
  - outData and outAddr=3 stay stable; no beat is lost or duplicated; the extra start is ignored.
- Wrap-around: first=30, last=1.
  - Expect exactly 4 beats with addresses 30, 31, 0, 1; outLast on address 1.
- Single register: first=last=7 with reg[7]=0xDEADBEEF.
  - Expect one beat with data 0xDEADBEEF, outLast=1, then done.
- Reset mid-dump: drop rst during beat 10.
  - outValid, busy and outData go to 0 immediately, without a clock edge.
  - After release, a new start with first=0, last=0 yields 1 correct beat.
- REG_DUMP_CHECKSUM_EN defined: reg0=1, reg1=2, reg2=4, range 0..2.
  - Expect 4 beats; the last carries data 0x7, outAddr=0, outLast=1; the beat for reg2 has outLast=0.
